pg_rule_arbiter: RTL

PG_RULE_ARBITER -- requirements
Module: pg_rule_arbiter

---
 rtl/pg_rule_arbiter_pkg.sv | 23 ++
 rtl/rr_prio_select.sv | 35 +++
 rtl/pg_rule_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pg_rule_arbiter_pkg.sv
// Shared types and constants for the port_group rule arbiter.
// Holds the FSM state type, requester limits and channel width.
package pg_rule_arbiter_pkg;

  localparam int MAX_IN = 8;
  localparam int CH_W   = 3;
  localparam int CNT_W  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Cyclic successor of a requester index within n requesters.
  function automatic logic [CH_W-1:0] ptr_inc(
    input logic [CH_W-1:0] g,
    input int              n
  );
    if (int'(g) >= n - 1) return '0;
    return g + 1'b1;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Cyclic priority select: first request at or after ptr.
// Produces a one-hot grant and a valid flag.
module rr_prio_select
  import pg_rule_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic            vld
);

  logic [CH_W:0] pos;
  logic          hit;

  always_comb begin
    gnt = '0;
    hit = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (CH_W+1)'(k);
      if (pos >= (CH_W+1)'(N)) pos = pos - (CH_W+1)'(N);
      for (int j = 0; j < N; j++) begin
        if (!hit && req[j] && pos == (CH_W+1)'(j)) begin
          gnt[j] = 1'b1;
          hit    = 1'b1;
        end
      end
    end
  end

  assign vld = hit;

endmodule

// File: rtl/pg_rule_arbiter.sv
// Packet-atomic round-robin merge of port_group rule streams.
// One registered output stage, per-requester packet stats.
module pg_rule_arbiter
  import pg_rule_arbiter_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0]         in_usr_sop,
  input  logic [NUM_IN-1:0]         in_usr_eop,
  input  logic [NUM_IN-1:0]         in_usr_valid,
  input  logic [NUM_IN*DATA_W-1:0]  in_usr_data,
  input  logic [NUM_IN*EMPTY_W-1:0] in_usr_empty,
  output logic [NUM_IN-1:0]         in_usr_ready,
  output logic                      out_usr_sop,
  output logic                      out_usr_eop,
  output logic                      out_usr_valid,
  output logic [DATA_W-1:0]         out_usr_data,
  output logic [EMPTY_W-1:0]        out_usr_empty,
  output logic [CH_W-1:0]           out_usr_channel,
  input  logic                      out_usr_ready,
  input  logic                      out_usr_almost_full,
  output logic [NUM_IN*CNT_W-1:0]   stats_pkt_cnt,
  output logic [CNT_W-1:0]          stats_drop_cnt
);

  state_t state;
  state_t state_nxt;

  logic [CH_W-1:0]    grant;
  logic [CH_W-1:0]    ptr;
  logic [NUM_IN-1:0]  sel_oh;
  logic               sel_vld;
  logic [CH_W-1:0]    sel_idx;
  logic               sel_sop;

  logic               cur_vld;
  logic               cur_sop;
  logic               cur_eop;
  logic [DATA_W-1:0]  cur_data;
  logic [EMPTY_W-1:0] cur_empty;

  logic take;
  logic accept;
  logic pkt_done;
  logic do_grant;
  logic do_drop;

  logic [CNT_W-1:0] pkt_cnt [NUM_IN];

  rr_prio_select #(
    .N (NUM_IN)
  ) u_sel (
    .req (in_usr_valid),
    .ptr (ptr),
    .gnt (sel_oh),
    .vld (sel_vld)
  );

  always_comb begin
    sel_idx   = '0;
    sel_sop   = 1'b0;
    cur_vld   = 1'b0;
    cur_sop   = 1'b0;
    cur_eop   = 1'b0;
    cur_data  = '0;
    cur_empty = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_oh[i]) begin
        sel_idx = CH_W'(i);
        sel_sop = in_usr_sop[i];
      end
      if (grant == CH_W'(i)) begin
        cur_vld   = in_usr_valid[i];
        cur_sop   = in_usr_sop[i];
        cur_eop   = in_usr_eop[i];
        cur_data  = in_usr_data[i*DATA_W +: DATA_W];
        cur_empty = in_usr_empty[i*EMPTY_W +: EMPTY_W];
      end
    end
  end

  assign take     = ~out_usr_valid | out_usr_ready;
  assign accept   = (state == BUSY) & cur_vld & take;
  assign pkt_done = accept & cur_eop;

  // A mid-packet flit at the selected slot is flushed instead of granted.
  assign do_grant = (state == IDLE) & sel_vld & sel_sop
                  & ~out_usr_almost_full;
  assign do_drop  = (state == IDLE) & sel_vld & ~sel_sop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (do_grant) state_nxt = BUSY;
      BUSY:    if (pkt_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_usr_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (state == BUSY && grant == CH_W'(i))
        in_usr_ready[i] = take;
      if (do_drop && sel_oh[i])
        in_usr_ready[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      grant           <= '0;
      ptr             <= '0;
      out_usr_valid   <= 1'b0;
      out_usr_sop     <= 1'b0;
      out_usr_eop     <= 1'b0;
      out_usr_data    <= '0;
      out_usr_empty   <= '0;
      out_usr_channel <= '0;
      stats_drop_cnt  <= '0;
      for (int i = 0; i < NUM_IN; i++)
        pkt_cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      if (do_grant)
        grant <= sel_idx;
      if (pkt_done)
        ptr <= ptr_inc(grant, NUM_IN);
      if (accept) begin
        out_usr_valid   <= 1'b1;
        out_usr_sop     <= cur_sop;
        out_usr_eop     <= cur_eop;
        out_usr_data    <= cur_data;
        out_usr_empty   <= cur_empty;
        out_usr_channel <= grant;
      end else if (out_usr_ready) begin
        out_usr_valid <= 1'b0;
      end
      if (do_drop)
        stats_drop_cnt <= stats_drop_cnt + 32'd1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (pkt_done && grant == CH_W'(i))
          pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_stats
    assign stats_pkt_cnt[g*CNT_W +: CNT_W] = pkt_cnt[g];
  end

endmodule
